id_ex_hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the ID/EX pipeline register and the front end (PC, IF/ID).
- Detects load-use hazards and inserts bubbles into ID/EX.
- Flushes wrong-path instructions after a taken branch resolves in EX.
- Freezes the whole front end while data memory is busy.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/id_ex_hazard_ctrl_if.sv | 33 +++
 rtl/id_ex_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_ctrl_if.sv
// Decode/EX hazard inputs and front-end/ID-EX control outputs of the hazard controller.
// The controller binds to the slave side; the pipeline (or a bench) drives the master side.
interface id_ex_hazard_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] IDRs1;
  logic [ADDR_W-1:0] IDRs2;
  logic              IDUsesRs2;
  logic              EXMemRead;
  logic [ADDR_W-1:0] EXRd;
  logic              EXBranchTaken;
  logic              MemBusy;
  logic              CntClear;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              IFIDFlush;
  logic              IDEXWrite;
  logic              IDEXFlush;
  logic [1:0]        State;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output IDRs1, IDRs2, IDUsesRs2, EXMemRead, EXRd, EXBranchTaken, MemBusy, CntClear,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, State, StallCount, FlushCount
  );

  modport slave (
    input  IDRs1, IDRs2, IDUsesRs2, EXMemRead, EXRd, EXBranchTaken, MemBusy, CntClear,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, State, StallCount, FlushCount
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use bubbles, taken-branch flushes, memory-busy freeze,
// and saturating stall/flush event counters. Outputs are Mealy on the registered state.
module id_ex_hazard_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  id_ex_hazard_ctrl_if.slave   bus
);

  localparam int CMAX  = (LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES;
  localparam int CTR_W = (CMAX < 2) ? 1 : $clog2(CMAX);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, MEMWAIT = 2'd3} state_e;

  state_e           state_q, state_d, sav_q, sav_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic hz, freeze, do_stall, do_flush;
  logic pc_w, ifid_w, ifid_fl, idex_w, idex_fl;

  always_comb begin
    hz = bus.EXMemRead && (bus.EXRd != '0) &&
         ((bus.EXRd == bus.IDRs1) || (bus.IDUsesRs2 && (bus.EXRd == bus.IDRs2)));
    freeze   = 1'b0;
    do_stall = 1'b0;
    do_flush = 1'b0;
    state_d  = state_q;
    ctr_d    = ctr_q;
    sav_d    = sav_q;

    case (state_q)
      RUN: begin
        if (bus.MemBusy) begin
          freeze  = 1'b1;
          sav_d   = RUN;
          state_d = MEMWAIT;
        end else if (bus.EXBranchTaken) begin
          do_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            ctr_d   = CTR_W'(FLUSH_CYCLES - 1);
          end
        end else if (hz) begin
          do_stall = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            ctr_d   = CTR_W'(LOAD_STALL - 1);
          end
        end
      end
      STALL, FLUSH: begin
        // ctr is held across a memory freeze so the remaining bubbles/flushes resume intact
        if (bus.MemBusy) begin
          freeze  = 1'b1;
          sav_d   = state_q;
          state_d = MEMWAIT;
        end else begin
          do_stall = (state_q == STALL);
          do_flush = (state_q == FLUSH);
          ctr_d    = ctr_q - CTR_W'(1);
          if (ctr_q == CTR_W'(1)) state_d = RUN;
        end
      end
      default: begin
        // the exit cycle stays frozen too; the held pipeline re-presents its work afterwards
        freeze = 1'b1;
        if (!bus.MemBusy) state_d = sav_q;
      end
    endcase

    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    if (freeze) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_w = 1'b0;
    end else if (do_flush) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (do_stall) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_fl = 1'b1;
    end
    if (!Reset) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.CntClear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_w && !(&stall_cnt_q))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_fl && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= RUN;
      ctr_q       <= '0;
      sav_q       <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      sav_q       <= sav_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCWrite    = pc_w;
  assign bus.IFIDWrite  = ifid_w;
  assign bus.IFIDFlush  = ifid_fl;
  assign bus.IDEXWrite  = idex_w;
  assign bus.IDEXFlush  = idex_fl;
  assign bus.State      = state_q;
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: two configurations share one stimulus stream and are each
// checked every cycle against a remaining-work model, plus hand-computed literal expectations.
module tb_id_ex_hazard_ctrl;

  localparam int LS_A = 1, FC_A = 1, CW_A = 16;
  localparam int LS_B = 3, FC_B = 2, CW_B = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [15:0] rs1, rs2, rd;
  logic        uses2, memrd, br, mbusy, clr;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  id_ex_hazard_ctrl_if #(.ADDR_W(16), .CNT_W(CW_A)) ia ();
  id_ex_hazard_ctrl_if #(.ADDR_W(16), .CNT_W(CW_B)) ib ();

  assign ia.IDRs1 = rs1;  assign ia.IDRs2 = rs2;  assign ia.IDUsesRs2 = uses2;
  assign ia.EXMemRead = memrd;  assign ia.EXRd = rd;  assign ia.EXBranchTaken = br;
  assign ia.MemBusy = mbusy;  assign ia.CntClear = clr;
  assign ib.IDRs1 = rs1;  assign ib.IDRs2 = rs2;  assign ib.IDUsesRs2 = uses2;
  assign ib.EXMemRead = memrd;  assign ib.EXRd = rd;  assign ib.EXBranchTaken = br;
  assign ib.MemBusy = mbusy;  assign ib.CntClear = clr;

  id_ex_hazard_ctrl #(.ADDR_W(16), .LOAD_STALL(LS_A), .FLUSH_CYCLES(FC_A), .CNT_W(CW_A))
    dut_a (.CLK(CLK), .Reset(rst_n), .bus(ia));
  id_ex_hazard_ctrl #(.ADDR_W(16), .LOAD_STALL(LS_B), .FLUSH_CYCLES(FC_B), .CNT_W(CW_B))
    dut_b (.CLK(CLK), .Reset(rst_n), .bus(ib));

  // Model: remaining bubble/flush cycles, a "waiting on memory" flag, and plain event tallies.
  typedef struct {int stall_left; int flush_left; bit waiting; int scnt; int fcnt;} mst_t;
  typedef struct {bit pcw; bit ifw; bit ifl; bit idw; bit idl; int st;} mout_t;

  mst_t ma = '{0, 0, 1'b0, 0, 0};
  mst_t mb = '{0, 0, 1'b0, 0, 0};

  function automatic bit hazard();
    return memrd && rd != 0 && (rd == rs1 || (uses2 && rd == rs2));
  endfunction

  function automatic mout_t mo(mst_t m);
    mout_t o;
    o.st = m.waiting ? 3 : (m.stall_left > 0) ? 1 : (m.flush_left > 0) ? 2 : 0;
    o.pcw = 1; o.ifw = 1; o.idw = 1; o.ifl = 0; o.idl = 0;
    if (!rst_n) begin
      o.pcw = 0; o.ifw = 0; o.idw = 0; o.ifl = 1; o.idl = 1;
    end else if (m.waiting || mbusy) begin
      o.pcw = 0; o.ifw = 0; o.idw = 0;
    end else if (m.flush_left > 0 || (m.stall_left == 0 && br)) begin
      o.ifl = 1; o.idl = 1;
    end else if (m.stall_left > 0 || hazard()) begin
      o.pcw = 0; o.ifw = 0; o.idl = 1;
    end
    return o;
  endfunction

  function automatic mst_t mn(mst_t m, mout_t o, int ls, int fc, int cw);
    mst_t n = m;
    int top = (1 << cw) - 1;
    if (!rst_n) return '{0, 0, 1'b0, 0, 0};
    if (clr) begin
      n.scnt = 0; n.fcnt = 0;
    end else begin
      if (!o.pcw && n.scnt < top) n.scnt++;
      if (o.ifl && n.fcnt < top) n.fcnt++;
    end
    if (m.waiting) n.waiting = mbusy;
    else if (mbusy) n.waiting = 1;
    else if (m.stall_left > 0) n.stall_left--;
    else if (m.flush_left > 0) n.flush_left--;
    else if (br) n.flush_left = fc - 1;
    else if (hazard()) n.stall_left = ls - 1;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    mout_t ea, eb;
    ea = mo(ma);
    eb = mo(mb);
    chk("a_PCWrite", ia.PCWrite, ea.pcw);    chk("b_PCWrite", ib.PCWrite, eb.pcw);
    chk("a_IFIDWrite", ia.IFIDWrite, ea.ifw); chk("b_IFIDWrite", ib.IFIDWrite, eb.ifw);
    chk("a_IFIDFlush", ia.IFIDFlush, ea.ifl); chk("b_IFIDFlush", ib.IFIDFlush, eb.ifl);
    chk("a_IDEXWrite", ia.IDEXWrite, ea.idw); chk("b_IDEXWrite", ib.IDEXWrite, eb.idw);
    chk("a_IDEXFlush", ia.IDEXFlush, ea.idl); chk("b_IDEXFlush", ib.IDEXFlush, eb.idl);
    chk("a_State", int'(ia.State), ea.st);    chk("b_State", int'(ib.State), eb.st);
    chk("a_StallCount", int'(ia.StallCount), ma.scnt);
    chk("b_StallCount", int'(ib.StallCount), mb.scnt);
    chk("a_FlushCount", int'(ia.FlushCount), ma.fcnt);
    chk("b_FlushCount", int'(ib.FlushCount), mb.fcnt);
    ma = mn(ma, ea, LS_A, FC_A, CW_A);
    mb = mn(mb, eb, LS_B, FC_B, CW_B);
  end

  task automatic cycle();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; uses2 = 0; memrd = 0; br = 0; mbusy = 0; clr = 0;
  endtask

  task automatic set_hz(input int r1, input int r2, input int d, input bit u2);
    memrd = 1; rs1 = 16'(r1); rs2 = 16'(r2); rd = 16'(d); uses2 = u2;
  endtask

  task automatic clear_cnt();
    idle(); clr = 1; cycle(); clr = 0;
  endtask

  initial begin
    idle();
    // reset with busy + branch pending: outputs forced, everything zero
    rst_n = 0; mbusy = 1; br = 1;
    cycle(); cycle(); #1;
    chk("rst_a_PCWrite", ia.PCWrite, 0);
    chk("rst_a_IFIDFlush", ia.IFIDFlush, 1);
    chk("rst_b_IDEXFlush", ib.IDEXFlush, 1);
    chk("rst_a_State", int'(ia.State), 0);
    chk("rst_b_StallCount", int'(ib.StallCount), 0);
    cycle();
    rst_n = 1; idle(); #1;
    chk("rel_a_PCWrite", ia.PCWrite, 1);
    chk("rel_a_IFIDFlush", ia.IFIDFlush, 0);
    chk("rel_b_State", int'(ib.State), 0);
    cycle();

    // single-cycle load-use on rs1
    clear_cnt();
    set_hz(5, 0, 5, 0); #1;
    chk("lu_a_PCWrite", ia.PCWrite, 0);
    chk("lu_a_IFIDWrite", ia.IFIDWrite, 0);
    chk("lu_a_IDEXFlush", ia.IDEXFlush, 1);
    chk("lu_a_IDEXWrite", ia.IDEXWrite, 1);
    cycle();
    idle(); #1;
    chk("lu_a_go", ia.PCWrite, 1);
    chk("lu_a_StallCount", int'(ia.StallCount), 1);
    cycle(); cycle(); cycle();
    set_hz(0, 0, 0, 0); #1;
    chk("r0_a_PCWrite", ia.PCWrite, 1);
    chk("r0_b_PCWrite", ib.PCWrite, 1);
    cycle();
    set_hz(1, 5, 5, 0); #1;
    chk("rs2nouse_a_PCWrite", ia.PCWrite, 1);
    cycle();
    set_hz(1, 5, 5, 1); #1;
    chk("rs2use_a_PCWrite", ia.PCWrite, 0);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // three-bubble stall interrupted by a two-cycle memory freeze
    clear_cnt();
    set_hz(5, 0, 5, 0); #1;
    chk("ms_b_st0", int'(ib.State), 0);
    chk("ms_b_PCWrite0", ib.PCWrite, 0);
    cycle();
    mbusy = 1; #1;
    chk("ms_b_st1", int'(ib.State), 1);
    cycle(); #1;
    chk("ms_b_st2", int'(ib.State), 3);
    cycle();
    mbusy = 0; #1;
    chk("ms_b_st3", int'(ib.State), 3);
    chk("ms_b_exit_PCWrite", ib.PCWrite, 0);
    cycle(); #1;
    chk("ms_b_st4", int'(ib.State), 1);
    cycle(); #1;
    chk("ms_b_st5", int'(ib.State), 1);
    cycle();
    idle(); #1;
    chk("ms_b_st6", int'(ib.State), 0);
    chk("ms_b_StallCount", int'(ib.StallCount), 6);
    cycle();

    // taken branch beats a coincident hazard; two flush cycles on config B
    clear_cnt();
    set_hz(5, 0, 5, 0); br = 1; #1;
    chk("br_b_IFIDFlush", ib.IFIDFlush, 1);
    chk("br_b_PCWrite", ib.PCWrite, 1);
    chk("br_b_IDEXFlush", ib.IDEXFlush, 1);
    cycle();
    idle(); #1;
    chk("br_b_st", int'(ib.State), 2);
    chk("br_b_IFIDFlush2", ib.IFIDFlush, 1);
    chk("br_a_go", ia.IFIDFlush, 0);
    cycle(); #1;
    chk("br_b_st_end", int'(ib.State), 0);
    chk("br_b_FlushCount", int'(ib.FlushCount), 2);
    chk("br_b_StallCount", int'(ib.StallCount), 0);
    cycle();

    // busy beats branch; the branch is re-presented after the freeze
    clear_cnt();
    mbusy = 1; br = 1; #1;
    chk("mb_a_IFIDFlush", ia.IFIDFlush, 0);
    chk("mb_a_PCWrite", ia.PCWrite, 0);
    cycle(); #1;
    chk("mb_a_st", int'(ia.State), 3);
    mbusy = 0; #1;
    chk("mb_a_exit_PCWrite", ia.PCWrite, 0);
    chk("mb_a_exit_IFIDFlush", ia.IFIDFlush, 0);
    cycle(); #1;
    chk("mb_a_st_run", int'(ia.State), 0);
    chk("mb_a_reflush", ia.IFIDFlush, 1);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // 20 held stall cycles saturate the 4-bit counter; clear wins over increment
    clear_cnt();
    set_hz(7, 0, 7, 0);
    repeat (20) cycle();
    #1;
    chk("sat_b_StallCount", int'(ib.StallCount), 15);
    chk("sat_a_StallCount", int'(ia.StallCount), 20);
    clr = 1; #1;
    chk("clr_b_PCWrite", ib.PCWrite, 0);
    cycle();
    clr = 0; idle(); #1;
    chk("clr_b_StallCount", int'(ib.StallCount), 0);
    chk("clr_a_StallCount", int'(ia.StallCount), 0);
    cycle(); cycle(); cycle();

    // mixed traffic, including mid-operation resets
    repeat (80) begin
      rst_n = ($urandom_range(0, 29) != 0);
      mbusy = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 4) == 0);
      memrd = $urandom_range(0, 1);
      uses2 = $urandom_range(0, 1);
      rs1   = 16'($urandom_range(0, 3));
      rs2   = 16'($urandom_range(0, 3));
      rd    = 16'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    rst_n = 1; idle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
